// File: rtl/word_serializer.sv
// Word-to-chunk serializer: captures a DATA_W-bit word over valid/ready and
// streams it out as DATA_W/CHUNK_W chunks, MSB-first or LSB-first.
module word_serializer #(
    parameter int DATA_W    = 32,
    parameter int CHUNK_W   = 8,
    parameter int IDX_W     = 2,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CHUNK_W-1:0] out_data,
    output logic [IDX_W-1:0]   out_idx,
    output logic               out_last,
    output logic               busy
);

    localparam int NCHUNK = DATA_W / CHUNK_W;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  word_q, word_d;
    logic [IDX_W-1:0]   idx_q, idx_d;

    logic [CHUNK_W-1:0] chunks [NCHUNK];
    logic [CHUNK_W-1:0] chunk_sel;
    logic               sending;
    logic               is_last;
    logic               take_word;

    // Chunk k is the k-th chunk on the wire, whichever end it comes from.
    for (genvar g = 0; g < NCHUNK; g++) begin : g_chunk
        if (MSB_FIRST) begin : g_msb
            assign chunks[g] = word_q[DATA_W-1-g*CHUNK_W -: CHUNK_W];
        end else begin : g_lsb
            assign chunks[g] = word_q[g*CHUNK_W +: CHUNK_W];
        end
    end

    always_comb begin
        chunk_sel = '0;
        for (int i = 0; i < NCHUNK; i++) begin
            if (idx_q == IDX_W'(i)) begin
                chunk_sel = chunks[i];
            end
        end
    end

    assign sending   = (state_q == SEND);
    assign is_last   = (idx_q == IDX_W'(NCHUNK - 1));
    // The last chunk leaving frees the register in the same cycle.
    assign in_ready  = !reset && (!sending || (is_last && out_ready));
    assign take_word = in_valid && in_ready;

    assign out_valid = sending && !reset;
    assign out_data  = out_valid ? chunk_sel : '0;
    assign out_idx   = out_valid ? idx_q : '0;
    assign out_last  = out_valid && is_last;
    assign busy      = sending;

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (take_word) begin
                    word_d  = in_data;
                    idx_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (out_ready) begin
                    if (!is_last) begin
                        idx_d = idx_q + IDX_W'(1);
                    end else if (take_word) begin
                        word_d = in_data;
                        idx_d  = '0;
                    end else begin
                        idx_d   = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            word_q  <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            idx_q   <= idx_d;
        end
    end

endmodule

// File: tb/tb_word_serializer.sv
// Bench for word_serializer: MSB-first and LSB-first 32/8 instances plus an
// 8/8 degenerate instance, checked against a chunk-queue reference model.
module tb_word_serializer;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_data;
    logic        out_ready;

    logic        in_ready_m, out_valid_m, out_last_m, busy_m;
    logic [7:0]  out_data_m;
    logic [1:0]  out_idx_m;
    logic        in_ready_l, out_valid_l, out_last_l, busy_l;
    logic [7:0]  out_data_l;
    logic [1:0]  out_idx_l;

    logic        reset_d, in_valid_d, out_ready_d;
    logic [7:0]  in_data_d;
    logic        in_ready_d, out_valid_d, out_last_d, busy_d;
    logic [7:0]  out_data_d;
    logic [0:0]  out_idx_d;

    int checks = 0;
    int failures = 0;

    logic [7:0] qm[$];
    logic [7:0] ql[$];
    logic [7:0] acc_m[$];
    logic [7:0] acc_l[$];

    always #5 clk = ~clk;

    word_serializer #(
        .DATA_W(32), .CHUNK_W(8), .IDX_W(2), .MSB_FIRST(1'b1)
    ) dut_m (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready_m), .in_data(in_data),
        .out_valid(out_valid_m), .out_ready(out_ready),
        .out_data(out_data_m), .out_idx(out_idx_m),
        .out_last(out_last_m), .busy(busy_m)
    );

    word_serializer #(
        .DATA_W(32), .CHUNK_W(8), .IDX_W(2), .MSB_FIRST(1'b0)
    ) dut_l (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready_l), .in_data(in_data),
        .out_valid(out_valid_l), .out_ready(out_ready),
        .out_data(out_data_l), .out_idx(out_idx_l),
        .out_last(out_last_l), .busy(busy_l)
    );

    word_serializer #(
        .DATA_W(8), .CHUNK_W(8), .IDX_W(1), .MSB_FIRST(1'b1)
    ) dut_d (
        .clk(clk), .reset(reset_d),
        .in_valid(in_valid_d), .in_ready(in_ready_d), .in_data(in_data_d),
        .out_valid(out_valid_d), .out_ready(out_ready_d),
        .out_data(out_data_d), .out_idx(out_idx_d),
        .out_last(out_last_d), .busy(busy_d)
    );

    // Reference: a word becomes four chunks queued in wire order.
    function automatic void push_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) begin
            qm.push_back(8'((w >> (8 * (3 - k))) & 32'hFF));
            ql.push_back(8'((w >> (8 * k)) & 32'hFF));
        end
    endfunction

    function automatic logic [13:0] exp_half(input bit msb);
        logic v, l, b, ir;
        logic [7:0] d;
        logic [1:0] ix;
        v  = (qm.size() != 0) && !reset;
        d  = v ? (msb ? qm[0] : ql[0]) : 8'h00;
        ix = v ? 2'(4 - qm.size()) : 2'd0;
        l  = v && (qm.size() == 1);
        b  = (qm.size() != 0);
        ir = !reset && (qm.size() == 0 || (qm.size() == 1 && out_ready));
        return {ir, v, d, ix, l, b};
    endfunction

    function automatic logic [27:0] exp_all();
        return {exp_half(1'b1), exp_half(1'b0)};
    endfunction

    function automatic logic [27:0] obs();
        return {in_ready_m, out_valid_m, out_data_m, out_idx_m, out_last_m,
                busy_m, in_ready_l, out_valid_l, out_data_l, out_idx_l,
                out_last_l, busy_l};
    endfunction

    function automatic logic [31:0] pack4(input logic [7:0] q[$]);
        return {q[0], q[1], q[2], q[3]};
    endfunction

    // Advance one clock, applying the handshakes of that edge to the model.
    task automatic tick();
        bit ir, pop;
        ir  = !reset && (qm.size() == 0 || (qm.size() == 1 && out_ready));
        pop = !reset && (qm.size() != 0) && out_ready;
        @(posedge clk);
        if (reset) begin
            qm.delete();
            ql.delete();
        end else begin
            if (pop) begin
                acc_m.push_back(qm.pop_front());
                acc_l.push_back(ql.pop_front());
            end
            if (in_valid && ir) push_word(in_data);
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        in_valid = 1'b1;
        in_data = $urandom;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (obs() !== exp_all()) begin
                failures++;
                $display("FAIL reset cyc=%0d got=%h want=%h", i, obs(), exp_all());
            end
            checks++;
            if (in_ready_m !== 1'b0 || out_valid_m !== 1'b0 || out_data_m !== 8'h00) begin
                failures++;
                $display("FAIL reset_outs cyc=%0d got=%b%b%h want=000", i,
                         in_ready_m, out_valid_m, out_data_m);
            end
            tick();
        end
        reset = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready_m !== 1'b1 || in_ready_l !== 1'b1) begin
            failures++;
            $display("FAIL reset_release got=%b%b want=11", in_ready_m, in_ready_l);
        end
        tick();
    endtask

    task automatic test_order();
        acc_m.delete();
        acc_l.delete();
        in_valid = 1'b1;
        in_data = 32'd16835;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (obs() !== exp_all()) begin
                failures++;
                $display("FAIL order cyc=%0d got=%h want=%h", i, obs(), exp_all());
            end
            tick();
            in_valid = 1'b0;
        end
        checks++;
        if (acc_m.size() != 4 || pack4(acc_m) !== 32'h000041C3) begin
            failures++;
            $display("FAIL order_msb n=%0d got=%h want=000041c3", acc_m.size(), pack4(acc_m));
        end
        checks++;
        if (acc_l.size() != 4 || pack4(acc_l) !== 32'hC3410000) begin
            failures++;
            $display("FAIL order_lsb n=%0d got=%h want=c3410000", acc_l.size(), pack4(acc_l));
        end
    endtask

    task automatic test_backpressure();
        logic [6:0] pat;
        pat = 7'b1001101;
        acc_m.delete();
        acc_l.delete();
        in_valid = 1'b1;
        in_data = 32'hDEADBEEF;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        in_data = $urandom;
        for (int i = 0; i < 7; i++) begin
            out_ready = pat[6 - i];
            @(negedge clk);
            checks++;
            if (obs() !== exp_all()) begin
                failures++;
                $display("FAIL backpressure cyc=%0d got=%h want=%h", i, obs(), exp_all());
            end
            tick();
        end
        @(negedge clk);
        checks++;
        if (acc_m.size() != 4 || pack4(acc_m) !== 32'hDEADBEEF || busy_m !== 1'b0) begin
            failures++;
            $display("FAIL backpressure_seq got=%h busy=%b want=deadbeef busy=0",
                     pack4(acc_m), busy_m);
        end
    endtask

    task automatic test_back_to_back();
        int run;
        run = 0;
        acc_m.delete();
        acc_l.delete();
        in_valid = 1'b1;
        in_data = 32'h11223344;
        out_ready = 1'b1;
        tick();
        in_data = 32'hAABBCCDD;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            checks++;
            if (obs() !== exp_all()) begin
                failures++;
                $display("FAIL back_to_back cyc=%0d got=%h want=%h", i, obs(), exp_all());
            end
            if (out_valid_m) run++;
            if (i == 3) begin
                checks++;
                if (in_ready_m !== 1'b1 || out_data_m !== 8'h44) begin
                    failures++;
                    $display("FAIL b2b_handover got=%b/%h want=1/44", in_ready_m, out_data_m);
                end
            end
            tick();
            if (i == 3) in_valid = 1'b0;
        end
        checks++;
        if (run != 8 || acc_m.size() != 8) begin
            failures++;
            $display("FAIL b2b_bubble got=%0d/%0d want=8/8", run, acc_m.size());
        end
        checks++;
        if ({pack4(acc_m), acc_m[4], acc_m[5], acc_m[6], acc_m[7]} !== 64'h11223344AABBCCDD) begin
            failures++;
            $display("FAIL b2b_data got=%h%h%h%h%h want=11223344aabbccdd",
                     pack4(acc_m), acc_m[4], acc_m[5], acc_m[6], acc_m[7]);
        end
    endtask

    task automatic test_mid_reset();
        in_valid = 1'b1;
        in_data = 32'hCAFEF00D;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (obs() !== exp_all()) begin
                failures++;
                $display("FAIL midreset_pre cyc=%0d got=%h want=%h", i, obs(), exp_all());
            end
            tick();
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        acc_m.delete();
        acc_l.delete();
        in_valid = 1'b1;
        in_data = 32'h01020304;
        @(negedge clk);
        checks++;
        if (out_valid_m !== 1'b0 || busy_m !== 1'b0 || in_ready_m !== 1'b1) begin
            failures++;
            $display("FAIL midreset_flush got=%b%b%b want=001",
                     out_valid_m, busy_m, in_ready_m);
        end
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (obs() !== exp_all()) begin
                failures++;
                $display("FAIL midreset_post cyc=%0d got=%h want=%h", i, obs(), exp_all());
            end
            tick();
        end
        checks++;
        if (acc_m.size() != 4 || pack4(acc_m) !== 32'h01020304) begin
            failures++;
            $display("FAIL midreset_seq n=%0d got=%h want=01020304", acc_m.size(), pack4(acc_m));
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 49) == 0);
            in_valid = $urandom_range(0, 2) != 0;
            in_data = $urandom;
            out_ready = $urandom_range(0, 3) != 0;
            @(negedge clk);
            checks++;
            if (obs() !== exp_all()) begin
                failures++;
                $display("FAIL random cyc=%0d got=%h want=%h", i, obs(), exp_all());
            end
            tick();
        end
        reset = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic test_degenerate();
        bit held, ir;
        logic [7:0] hb;
        logic [12:0] exp_d;
        logic [12:0] got_d;
        held = 1'b0;
        hb = 8'h00;
        reset_d = 1'b1;
        in_valid_d = 1'b0;
        out_ready_d = 1'b0;
        @(posedge clk);
        #1;
        reset_d = 1'b0;
        for (int i = 0; i < 120; i++) begin
            in_valid_d = $urandom_range(0, 1);
            in_data_d = 8'($urandom);
            out_ready_d = $urandom_range(0, 1);
            ir = !held || out_ready_d;
            @(negedge clk);
            exp_d = {ir, held, held ? hb : 8'h00, 1'b0, held, held};
            got_d = {in_ready_d, out_valid_d, out_data_d, out_idx_d, out_last_d, busy_d};
            checks++;
            if (got_d !== exp_d) begin
                failures++;
                $display("FAIL degenerate cyc=%0d got=%h want=%h", i, got_d, exp_d);
            end
            @(posedge clk);
            if (held && out_ready_d) held = 1'b0;
            if (in_valid_d && ir) begin
                held = 1'b1;
                hb = in_data_d;
            end
            #1;
        end
    endtask

    initial begin
        reset = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b0;
        reset_d = 1'b1;
        in_valid_d = 1'b0;
        in_data_d = '0;
        out_ready_d = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_order();
        test_backpressure();
        test_back_to_back();
        test_mid_reset();
        test_random();
        test_degenerate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
